// File: rtl/mul8_arb_pkg.sv
// Shared types and constants for the mul8_arb multiplier-sharing controller.
package mul8_arb_pkg;

  // Datapath width of the shared multiplier.
  localparam int unsigned DW = 8;

  // Width of one requester's operand slice inside the packed a/b buses.
  localparam int unsigned OpSliceW = DW;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StArm,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/mul8_arb_rr_arbiter.sv
// Combinational round-robin pick: first active request at or above ptr_i, wrapping to 0.
module rr_arbiter
  import mul8_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] gnt_o,
  output logic                 valid_o
);

  localparam int unsigned IdxW = $clog2(N);

  int unsigned j;

  // Walk N candidates starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr_i) + i;
      if (j >= N) begin
        j = j - N;
      end
      if (!valid_o && req_i[IdxW'(j)]) begin
        valid_o = 1'b1;
        gnt_o   = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/mul8_arb.sv
// Round-robin controller sharing one external iterative 8-bit multiplier among N requesters.
// Optional busy-phase timeout abort is built when MUL8_ARB_TIMEOUT_EN is defined.
module mul8_arb
  import mul8_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic [DW*N-1:0]      a_i,
  input  logic [DW*N-1:0]      b_i,
  output logic [N-1:0]         ack_o,
  output logic [DW-1:0]        p_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
`ifdef MUL8_ARB_TIMEOUT_EN
  output logic                 err_o,
`endif
  output logic                 mul_start_o,
  output logic [DW-1:0]        mul_a_o,
  output logic [DW-1:0]        mul_b_o,
  input  logic                 mul_busy_i,
  input  logic [DW-1:0]        mul_p_i
);

  localparam int unsigned IdxW = $clog2(N);

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   p_q, p_d;
  logic [N-1:0]    ack_q, ack_d;

  logic [IdxW-1:0] arb_gnt;
  logic            arb_valid;
  logic [DW-1:0]   a_sel, b_sel;

`ifdef MUL8_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Last counter value before the phase has used up its TIMEOUT cycles.
  localparam logic [CntW-1:0] CntLim = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  rr_arbiter #(
    .N (N)
  ) u_rr_arbiter (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // Operand mux for the requester the arbiter currently picks.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (arb_gnt == IdxW'(k)) begin
        a_sel = a_i[k*OpSliceW +: OpSliceW];
        b_sel = b_i[k*OpSliceW +: OpSliceW];
      end
    end
  end

  // Next-state logic for the sequencing FSM and all registered outputs.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    ack_d   = '0;
`ifdef MUL8_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // Holding off while busy absorbs the multiplier's power-up or post-reset self-run.
        if (arb_valid && !mul_busy_i) begin
          gnt_d   = arb_gnt;
          a_d     = a_sel;
          b_d     = b_sel;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StArm;
`ifdef MUL8_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StArm: begin
        if (mul_busy_i) begin
          state_d = StRun;
        end
`ifdef MUL8_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLim) begin
          state_d = StIdle;
          err_d   = 1'b1;
          p_d     = '0;
        end
`endif
      end
      StRun: begin
        if (!mul_busy_i) begin
          p_d     = mul_p_i;
          state_d = StDone;
          for (int unsigned k = 0; k < N; k++) begin
            ack_d[k] = (gnt_q == IdxW'(k));
          end
        end
`ifdef MUL8_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLim) begin
            state_d = StIdle;
            err_d   = 1'b1;
            p_d     = '0;
          end
        end
`endif
      end
      StDone: begin
        ptr_d   = (gnt_q == IdxW'(N - 1)) ? '0 : gnt_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      ack_q   <= ack_d;
    end
  end

`ifdef MUL8_ARB_TIMEOUT_EN
  // Busy-phase watchdog counter and its abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  assign mul_start_o = (state_q == StIssue);
  assign mul_a_o     = a_q;
  assign mul_b_o     = b_q;
  assign ack_o       = ack_q;
  assign p_o         = p_q;
  assign gnt_id_o    = gnt_q;

endmodule

// File: tb/tb_mul8_arb.sv
// Directed bench for mul8_arb with a 9-cycle shift-add multiplier model (busy high 8 cycles).
module tb_mul8_arb;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_i;
  logic [31:0]  a_i;
  logic [31:0]  b_i;
  logic [N-1:0] ack_o;
  logic [7:0]   p_o;
  logic [1:0]   gnt_id_o;
`ifdef MUL8_ARB_TIMEOUT_EN
  logic         err_o;
`endif
  logic         mul_start_o;
  logic [7:0]   mul_a_o;
  logic [7:0]   mul_b_o;
  logic         mul_busy_i;
  logic [7:0]   mul_p_i;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // External multiplier model: no reset, free-running once started.
  int         mcnt = 0;
  logic [7:0] mprod = 8'd0;
  logic       force_busy = 1'b0;

  mul8_arb #(
    .N       (N),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .ack_o       (ack_o),
    .p_o         (p_o),
    .gnt_id_o    (gnt_id_o),
`ifdef MUL8_ARB_TIMEOUT_EN
    .err_o       (err_o),
`endif
    .mul_start_o (mul_start_o),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_busy_i  (mul_busy_i),
    .mul_p_i     (mul_p_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mul_start_o) begin
      mcnt  <= 8;
      mprod <= mul_a_o * mul_b_o;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign mul_busy_i = (mcnt != 0) || force_busy;
  assign mul_p_i    = mprod;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [7:0] av, input logic [7:0] bv);
    a_i[k*8 +: 8] = av;
    b_i[k*8 +: 8] = bv;
  endtask

  // Step until an ack appears (bounded); a missing ack counts as a failure.
  task automatic wait_ack(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ack_o != '0) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    int  s;
    int  prev;
    bit  bad;
    bit  found;
    bit  prev_busy;
    int  n;
    int  exp_g [4];
    int  exp_p [4];

    rst_n = 1'b0;
    req_i = '0;
    a_i   = '0;
    b_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ack", 32'(ack_o), 32'd0);
    check("rst p", 32'(p_o), 32'd0);
    check("rst gnt", 32'(gnt_id_o), 32'd0);
    check("rst start", 32'(mul_start_o), 32'd0);
    check("rst mul_a", 32'(mul_a_o), 32'd0);
    check("rst mul_b", 32'(mul_b_o), 32'd0);
`ifdef MUL8_ARB_TIMEOUT_EN
    check("rst err", 32'(err_o), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Single requester, exact latency, late operand change ignored.
    set_op(0, 8'd3, 8'd5);
    req_i = 4'b0001;
    step();
    check("t1 start", 32'(mul_start_o), 32'd1);
    check("t1 mul_a", 32'(mul_a_o), 32'd3);
    check("t1 mul_b", 32'(mul_b_o), 32'd5);
    check("t1 gnt", 32'(gnt_id_o), 32'd0);
    set_op(0, 8'd100, 8'd100);
    step();
    check("t1 start pulse", 32'(mul_start_o), 32'd0);
    repeat (8) step();
    check("t1 ack early", 32'(ack_o), 32'd0);
    step();
    check("t1 ack", 32'(ack_o), 32'b0001);
    check("t1 p", 32'(p_o), 32'd15);
    req_i = '0;
    step();
    check("t1 ack pulse", 32'(ack_o), 32'd0);

    // Overflow on requester 2; request dropped right after grant.
    set_op(2, 8'd200, 8'd2);
    req_i = 4'b0100;
    step();
    check("t2 start", 32'(mul_start_o), 32'd1);
    check("t2 gnt", 32'(gnt_id_o), 32'd2);
    check("t2 mul_a", 32'(mul_a_o), 32'd200);
    s = cyc;
    req_i = '0;
    wait_ack("t2 ack seen");
    check("t2 ack", 32'(ack_o), 32'b0100);
    check("t2 p", 32'(p_o), 32'd144);
    check("t2 latency", 32'(cyc - s), 32'd10);
    step();

    // Contention from ptr=0: order 1,3,1,3, 12 cycles apart.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    set_op(1, 8'd7, 8'd9);
    set_op(3, 8'd16, 8'd17);
    req_i = 4'b1010;
    exp_g = '{1, 3, 1, 3};
    exp_p = '{63, 16, 63, 16};
    prev  = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack("t3 ack seen");
      check("t3 gnt", 32'(gnt_id_o), 32'(exp_g[i]));
      check("t3 ack", 32'(ack_o), 32'(1 << exp_g[i]));
      check("t3 p", 32'(p_o), 32'(exp_p[i]));
      if (i > 0) check("t3 spacing", 32'(cyc - prev), 32'd12);
      prev = cyc;
    end
    req_i = '0;
    step();

    // Multiplier busy after reset: no start until busy falls.
    rst_n = 1'b0;
    force_busy = 1'b1;
    #2;
    rst_n = 1'b1;
    set_op(0, 8'd6, 8'd7);
    req_i = 4'b0001;
    bad = 1'b0;
    repeat (20) begin
      step();
      if (mul_start_o) bad = 1'b1;
    end
    check("t4 no start while busy", 32'(bad), 32'd0);
    force_busy = 1'b0;
    step();
    check("t4 start", 32'(mul_start_o), 32'd1);
    s = cyc;
    wait_ack("t4 ack seen");
    check("t4 ack", 32'(ack_o), 32'b0001);
    check("t4 p", 32'(p_o), 32'd42);
    check("t4 latency", 32'(cyc - s), 32'd10);
    req_i = '0;
    step();

    // Reset in the middle of RUN; re-issue must wait for the multiplier.
    set_op(2, 8'd11, 8'd13);
    req_i = 4'b0100;
    step();
    check("t5 start", 32'(mul_start_o), 32'd1);
    check("t5 gnt", 32'(gnt_id_o), 32'd2);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("t5 rst ack", 32'(ack_o), 32'd0);
    check("t5 rst p", 32'(p_o), 32'd0);
    check("t5 rst gnt", 32'(gnt_id_o), 32'd0);
    check("t5 rst start", 32'(mul_start_o), 32'd0);
    check("t5 rst mul_a", 32'(mul_a_o), 32'd0);
    check("t5 rst mul_b", 32'(mul_b_o), 32'd0);
    #2;
    rst_n = 1'b1;
    found = 1'b0;
    prev_busy = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      prev_busy = mul_busy_i;
      step();
      n++;
      if (mul_start_o) begin
        found = 1'b1;
        break;
      end
    end
    check("t5 restart seen", 32'(found), 32'd1);
    check("t5 busy low at arb", 32'(prev_busy), 32'd0);
    check("t5 restart delayed", 32'(n >= 4), 32'd1);
    wait_ack("t5 ack seen");
    check("t5 ack", 32'(ack_o), 32'b0100);
    check("t5 gnt", 32'(gnt_id_o), 32'd2);
    check("t5 p", 32'(p_o), 32'd143);
    req_i = '0;
    step();

`ifdef MUL8_ARB_TIMEOUT_EN
    // Stuck busy: abort with err, no ack, pointer unchanged so requester 3 wins again.
    req_i = 4'b1010;
    step();
    check("t6 start", 32'(mul_start_o), 32'd1);
    check("t6 gnt", 32'(gnt_id_o), 32'd3);
    force_busy = 1'b1;
    found = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ack_o != '0) bad = 1'b1;
      if (err_o) begin
        found = 1'b1;
        break;
      end
    end
    check("t6 err seen", 32'(found), 32'd1);
    check("t6 no ack", 32'(bad), 32'd0);
    check("t6 p cleared", 32'(p_o), 32'd0);
    step();
    check("t6 err pulse", 32'(err_o), 32'd0);
    force_busy = 1'b0;
    wait_ack("t6 ack seen");
    check("t6 regrant", 32'(gnt_id_o), 32'd3);
    check("t6 ack", 32'(ack_o), 32'b1000);
    check("t6 p", 32'(p_o), 32'd16);
    req_i = '0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
